pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Registered successor to the combinational control decoder: decodes the ID-stage instruction into
//  EX/MEM/WB bundles and holds them in the ID/EX control register. Owns the pipeline hold logic:
//  load-use hazard stall, branch flush, external memory stall, and a multi-cycle MUL busy counter.
//  Sits between the IF/ID register and the EX stage; drives the pc_write/ifid_write enables.
// PARAMETERS
//  REG_AW    5  register-index width (rd/rs1/rs2)
//  MUL_LAT   3  EX-stage cycles for a MUL (1..15); 1 = single-cycle, no hold
//  EN_MUL    1  1 = decode opcode 0110011 with funct7 0000001 as MUL; 0 = treat it as plain R-type
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous reset, active-low
//  inst_i         in   32      instruction in IF/ID
//  inst_valid_i   in   1       inst_i valid; 0 = decode as bubble
//  flush_i        in   1       branch taken (from MEM); kill ID-stage instruction
//  stall_ext_i    in   1       data-memory stall; freeze ID/EX and counter
//  ex_signal_o    out  3       {ALUSrc, ALUOp[1:0]} (registered)
//  mem_signal_o   out  3       {Branch, MemRead, MemWrite} (registered)
//  wb_signal_o    out  2       {RegWrite, MemtoReg} (registered)
//  ex_mul_o       out  1       EX instruction is MUL (registered)
//  ex_rd_o        out  REG_AW  EX destination register, for forwarding (registered)
//  pc_write_o     out  1       PC update enable
//  ifid_write_o   out  1       IF/ID register update enable
//  ex_busy_o      out  1       MUL still executing
//  illegal_o      out  1       one-cycle pulse: unknown opcode entered EX as bubble
// BEHAVIOUR
//  Reset (rst_i=0, async): all registered outputs, the MUL counter and illegal_o are 0;
//   pc_write_o/ifid_write_o forced 0 while in reset.
//  Decode (combinational, on inst_i[6:0], funct7):
//   0000011 load : EX 000 MEM 010 WB 11 | 0100011 store: EX 100 MEM 001 WB 00
//   1100011 beq  : EX 001 MEM 100 WB 00 | 0110011 R    : EX 010 MEM 000 WB 10
//   0010011 addi : EX 111 MEM 000 WB 10 | MUL: as R plus ex_mul
//   other opcodes: all-zero bundle, flagged illegal. WB don't-cares are driven 0; no X on outputs.
//  rs2 counts as a source only for R/MUL/store/beq; rs1 for all decoded opcodes except illegal.
//  Hazard terms (from registered state):
//   load_use = MemRead_ex & ex_rd_o!=0 & (ex_rd_o==rs1 | (ex_rd_o==rs2 & uses_rs2)) & inst_valid_i
//   mul_hold = cnt!=0
//  Per-edge priority (one action per clock):
//   1 flush_i     : ID/EX <- bubble (all zero), cnt <- 0; a MUL in progress is aborted
//   2 stall_ext_i : ID/EX and cnt hold
//   3 mul_hold    : ID/EX holds, cnt <- cnt-1
//   4 load_use    : ID/EX <- bubble, cnt unchanged
//   5 normal      : ID/EX <- decode(inst_i) (bubble if !inst_valid_i);
//                   if the decode is MUL and MUL_LAT>1, cnt <- MUL_LAT-1
//  pc_write_o = ifid_write_o = rst_i & ~stall_ext_i & ~mul_hold & ~load_use
//   (flush_i does not hold the PC; the front end redirects).
//  ex_busy_o = mul_hold. A MUL therefore occupies EX for exactly MUL_LAT cycles absent stalls.
//  illegal_o: registered; 1 for one cycle when priority 5 loads an invalid opcode with inst_valid_i=1.
//  Back-to-back MULs: the second issues on the edge cnt reaches 0, so there is no gap cycle.
//  A load followed by a dependent MUL: one bubble, then the MUL issues normally.
//  rd=x0 never triggers load_use. A reset mid-MUL clears cnt immediately.
// STRUCTURE
//  pipe_ctrl_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_BEQ, OP_R, OP_IMM), FUNCT7_MUL,
//   bundle widths EX_W=3, MEM_W=3, WB_W=2, and the bundle bit positions.
//  Sub-module ctrl_decode: purely combinational inst -> {ex, mem, wb, mul, illegal, uses_rs2};
//   the top holds the ID/EX register, counter and hazard logic.
// TESTING
//  1 reset low mid-stream -> all registered outputs 0 at once; release -> pc_write_o=1.
//  2 lw x5 then add x6,x5,x1 -> one bubble (bundles 0), pc_write_o=0 for 1 cycle, add enters EX next.
//  3 lw x0 then add x6,x0,x1 -> no stall; lw x5 then sw x5 as rs2 -> stall.
//  4 MUL, MUL_LAT=3 -> ex_busy_o=1 for 2 cycles, pc_write_o=0 for 2; back-to-back MUL with no gap.
//  5 MUL with flush_i on 2nd cycle -> bubble next edge, ex_busy_o=0; stall_ext_i during MUL -> cnt frozen.
//  6 opcode 1111111 valid -> bundles 0, illegal_o single pulse; same with inst_valid_i=0 -> no pulse.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the ID/EX control unit: opcodes, bundle widths and bit positions.
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BEQ     = 7'b1100011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  localparam int EX_W  = 3;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  localparam int EX_ALUSRC   = 2;
  localparam int EX_ALUOP_HI = 1;
  localparam int EX_ALUOP_LO = 0;

  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // MUL_LAT is bounded to 15, so four bits always hold MUL_LAT-1.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic             mul;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode/funct7 decoder producing the EX/MEM/WB control bundles.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int EN_MUL = 1
) (
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    ctrl_o     = '0;
    illegal_o  = 1'b0;
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    unique case (opcode_i)
      OP_LOAD: begin
        ctrl_o.mem[MEM_READ]    = 1'b1;
        ctrl_o.wb[WB_REGWRITE]  = 1'b1;
        ctrl_o.wb[WB_MEMTOREG]  = 1'b1;
      end
      OP_STORE: begin
        ctrl_o.ex[EX_ALUSRC]    = 1'b1;
        ctrl_o.mem[MEM_WRITE]   = 1'b1;
        uses_rs2_o              = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.ex[EX_ALUOP_LO]  = 1'b1;
        ctrl_o.mem[MEM_BRANCH]  = 1'b1;
        uses_rs2_o              = 1'b1;
      end
      OP_R: begin
        ctrl_o.ex[EX_ALUOP_HI]  = 1'b1;
        ctrl_o.wb[WB_REGWRITE]  = 1'b1;
        ctrl_o.mul              = (EN_MUL != 0) && (funct7_i == FUNCT7_MUL);
        uses_rs2_o              = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.ex               = '1;
        ctrl_o.wb[WB_REGWRITE]  = 1'b1;
      end
      default: begin
        illegal_o  = 1'b1;
        uses_rs1_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control register with load-use, flush, external-stall and multi-cycle MUL hold logic.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int EN_MUL  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  input  logic              flush_i,
  input  logic              stall_ext_i,
  output logic [EX_W-1:0]   ex_signal_o,
  output logic [MEM_W-1:0]  mem_signal_o,
  output logic [WB_W-1:0]   wb_signal_o,
  output logic              ex_mul_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ex_busy_o,
  output logic              illegal_o
);

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);

  ctrl_t             dec;
  logic              dec_illegal;
  logic              dec_rs1;
  logic              dec_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              unused_funct3;

  ctrl_t             idex_q,    idex_d;
  logic [REG_AW-1:0] ex_rd_q,   ex_rd_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              illegal_q, illegal_d;

  logic              load_use;
  logic              mul_hold;

  ctrl_decode #(
    .EN_MUL (EN_MUL)
  ) u_decode (
    .opcode_i   (inst_i[6:0]),
    .funct7_i   (inst_i[31:25]),
    .ctrl_o     (dec),
    .illegal_o  (dec_illegal),
    .uses_rs1_o (dec_rs1),
    .uses_rs2_o (dec_rs2)
  );

  assign id_rd         = inst_i[7  +: REG_AW];
  assign id_rs1        = inst_i[15 +: REG_AW];
  assign id_rs2        = inst_i[20 +: REG_AW];
  assign unused_funct3 = ^inst_i[14:12];

  assign mul_hold = (cnt_q != '0);
  assign load_use = idex_q.mem[MEM_READ] && (ex_rd_q != '0) && inst_valid_i &&
                    (((ex_rd_q == id_rs1) && dec_rs1) || ((ex_rd_q == id_rs2) && dec_rs2));

  always_comb begin
    idex_d    = idex_q;
    ex_rd_d   = ex_rd_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    if (flush_i) begin
      idex_d  = '0;
      ex_rd_d = '0;
      cnt_d   = '0;
    end else if (!stall_ext_i) begin
      if (mul_hold) begin
        cnt_d = cnt_q - 1'b1;
      end else if (load_use || !inst_valid_i) begin
        idex_d  = '0;
        ex_rd_d = '0;
      end else begin
        idex_d    = dec;
        // Only instructions that write back expose a destination for forwarding.
        ex_rd_d   = dec.wb[WB_REGWRITE] ? id_rd : '0;
        illegal_d = dec_illegal;
        if (dec.mul && (MUL_LAT > 1)) begin
          cnt_d = MUL_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q    <= '0;
      ex_rd_q   <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      ex_rd_q   <= ex_rd_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_signal_o  = idex_q.ex;
  assign mem_signal_o = idex_q.mem;
  assign wb_signal_o  = idex_q.wb;
  assign ex_mul_o     = idex_q.mul;
  assign ex_rd_o      = ex_rd_q;
  assign ex_busy_o    = mul_hold;
  assign illegal_o    = illegal_q;

  // A flush does not hold the PC; the front end is redirecting anyway.
  assign pc_write_o   = rst_i && !stall_ext_i && !mul_hold && !load_use;
  assign ifid_write_o = pc_write_o;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_pipe_ctrl_unit;

  localparam int REG_AW  = 5;
  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        vld = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;

  logic [2:0]        ex_o;
  logic [2:0]        mem_o;
  logic [1:0]        wb_o;
  logic              mul_o;
  logic [REG_AW-1:0] rd_o;
  logic              pc_o;
  logic              ifid_o;
  logic              busy_o;
  logic              ill_o;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .REG_AW  (REG_AW),
    .MUL_LAT (MUL_LAT),
    .EN_MUL  (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .inst_i       (inst),
    .inst_valid_i (vld),
    .flush_i      (flush),
    .stall_ext_i  (stall),
    .ex_signal_o  (ex_o),
    .mem_signal_o (mem_o),
    .wb_signal_o  (wb_o),
    .ex_mul_o     (mul_o),
    .ex_rd_o      (rd_o),
    .pc_write_o   (pc_o),
    .ifid_write_o (ifid_o),
    .ex_busy_o    (busy_o),
    .illegal_o    (ill_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    bit         mul;
    bit         ill;
    bit         u1;
    bit         u2;
  } dec_t;

  function automatic dec_t mdec(logic [31:0] i);
    dec_t d;
    logic [7:0] b;
    d.mul = 0; d.ill = 0; d.u1 = 1; d.u2 = 0;
    case (i[6:0])
      7'b0000011: b = 8'b000_010_11;
      7'b0100011: begin b = 8'b100_001_00; d.u2 = 1; end
      7'b1100011: begin b = 8'b001_100_00; d.u2 = 1; end
      7'b0110011: begin b = 8'b010_000_10; d.u2 = 1; d.mul = (i[31:25] == 7'b0000001); end
      7'b0010011: b = 8'b111_000_10;
      default:    begin b = 8'b0; d.ill = 1; d.u1 = 0; end
    endcase
    {d.ex, d.mem, d.wb} = b;
    return d;
  endfunction

  logic [2:0] m_ex = '0;
  logic [2:0] m_mem = '0;
  logic [1:0] m_wb = '0;
  bit         m_mul = 0;
  bit         m_ill = 0;
  int         m_rd = 0;
  int         m_rem = 0;   // EX cycles the current MUL still has to stay after this one

  function automatic bit m_hazard();
    dec_t d = mdec(inst);
    return vld && m_mem[1] && (m_rd != 0) &&
           ((d.u1 && int'(inst[19:15]) == m_rd) || (d.u2 && int'(inst[24:20]) == m_rd));
  endfunction

  task automatic m_clear();
    m_ex = '0; m_mem = '0; m_wb = '0; m_mul = 0; m_rd = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    dec_t d;
    bit   hz;
    if (!rst_n) begin
      m_clear();
      m_ill = 0;
      m_rem = 0;
    end else begin
      d  = mdec(inst);
      hz = m_hazard();
      m_ill = 0;
      if (flush) begin
        m_clear();
        m_rem = 0;
      end else if (stall) begin
        m_rem = m_rem;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end else if (hz || !vld) begin
        m_clear();
      end else begin
        m_ex = d.ex; m_mem = d.mem; m_wb = d.wb; m_mul = d.mul;
        m_rd = d.wb[1] ? int'(inst[11:7]) : 0;
        m_ill = d.ill;
        if (d.mul) m_rem = MUL_LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_pc;
    exp_pc = rst_n && !stall && (m_rem == 0) && !m_hazard();
    chk("m_ex",   ex_o,   m_ex);
    chk("m_mem",  mem_o,  m_mem);
    chk("m_wb",   wb_o,   m_wb);
    chk("m_mul",  mul_o,  m_mul);
    chk("m_rd",   rd_o,   m_rd);
    chk("m_ill",  ill_o,  m_ill);
    chk("m_busy", busy_o, (m_rem > 0));
    chk("m_pc",   pc_o,   exp_pc);
    chk("m_ifid", ifid_o, exp_pc);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] r_t(int rd, int rs1, int rs2, logic [6:0] f7);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] i_t(logic [6:0] op, int rd, int rs1);
    return {12'd4, 5'(rs1), 3'b010, 5'(rd), op};
  endfunction

  function automatic logic [31:0] s_t(int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd9, 7'b0100011};
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op;
    logic [6:0] f7;
    case ($urandom_range(0, 5))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b1100011;
      3: op = 7'b0110011;
      4: op = 7'b0010011;
      default: op = 7'($urandom);
    endcase
    f7 = ($urandom_range(0, 1) != 0) ? 7'b0000001 : 7'b0000000;
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b000,
            5'($urandom_range(0, 3)), op};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] i, bit v, bit f, bit s);
    inst = i; vld = v; flush = f; stall = s;
    #1;
  endtask

  localparam logic [6:0] F7_MUL = 7'b0000001;

  initial begin
    drive(32'h0, 0, 0, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    chk("release_pc", pc_o, 1);

    // reset asserted mid-stream clears registered state immediately
    drive(i_t(7'b0000011, 5, 2), 1, 0, 0);
    cyc();
    chk("lw_mem", mem_o, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("rst_mem", mem_o, 0);
    chk("rst_wb", wb_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_pc", pc_o, 0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("rst_rel_pc", pc_o, 1);

    // load-use: lw x5 ; add x6,x5,x1
    drive(i_t(7'b0000011, 5, 2), 1, 0, 0);
    cyc();
    chk("lw_wb", wb_o, 2'b11);
    chk("lw_rd", rd_o, 5);
    drive(r_t(6, 5, 1, 7'd0), 1, 0, 0);
    chk("lu_pc", pc_o, 0);
    chk("lu_ifid", ifid_o, 0);
    cyc();
    chk("lu_bub_ex", ex_o, 0);
    chk("lu_bub_wb", wb_o, 0);
    chk("lu_pc_after", pc_o, 1);
    cyc();
    chk("add_ex", ex_o, 3'b010);
    chk("add_rd", rd_o, 6);

    // x0 never stalls; store rs2 does
    drive(i_t(7'b0000011, 0, 2), 1, 0, 0);
    cyc();
    drive(r_t(6, 0, 1, 7'd0), 1, 0, 0);
    chk("x0_pc", pc_o, 1);
    cyc();
    chk("x0_ex", ex_o, 3'b010);
    drive(i_t(7'b0000011, 5, 2), 1, 0, 0);
    cyc();
    drive(s_t(3, 5), 1, 0, 0);
    chk("sw_pc", pc_o, 0);
    cyc();
    chk("sw_bub", mem_o, 0);
    chk("sw_pc_after", pc_o, 1);
    drive(32'h0, 0, 0, 0);
    cyc();

    // MUL occupies EX for 3 cycles, back-to-back with no gap
    drive(r_t(7, 1, 2, F7_MUL), 1, 0, 0);
    cyc();
    drive(r_t(8, 1, 2, F7_MUL), 1, 0, 0);
    chk("mul_flag", mul_o, 1);
    chk("mul_busy1", busy_o, 1);
    chk("mul_pc1", pc_o, 0);
    cyc();
    chk("mul_busy2", busy_o, 1);
    chk("mul_pc2", pc_o, 0);
    cyc();
    chk("mul_busy3", busy_o, 0);
    chk("mul_pc3", pc_o, 1);
    chk("mul_rd", rd_o, 7);
    cyc();
    chk("mul2_rd", rd_o, 8);
    chk("mul2_busy", busy_o, 1);
    drive(32'h0, 0, 0, 0);
    cyc();
    cyc();
    chk("mul2_done", busy_o, 0);
    cyc();

    // flush aborts a MUL on its second cycle
    drive(r_t(7, 1, 2, F7_MUL), 1, 0, 0);
    cyc();
    drive(32'h0, 0, 0, 0);
    cyc();
    chk("fl_busy_pre", busy_o, 1);
    drive(32'h0, 0, 1, 0);
    cyc();
    chk("fl_mul", mul_o, 0);
    chk("fl_busy", busy_o, 0);
    chk("fl_ex", ex_o, 0);

    // external stall freezes the MUL counter
    drive(r_t(7, 1, 2, F7_MUL), 1, 0, 0);
    cyc();
    drive(32'h0, 0, 0, 1);
    cyc();
    cyc();
    chk("st_busy", busy_o, 1);
    chk("st_mul", mul_o, 1);
    drive(32'h0, 0, 0, 0);
    cyc();
    chk("st_busy2", busy_o, 1);
    cyc();
    chk("st_done", busy_o, 0);

    // illegal opcode pulses once; invalid slot never pulses
    drive(32'h0000_007F, 1, 0, 0);
    cyc();
    chk("ill_pulse", ill_o, 1);
    chk("ill_ex", ex_o, 0);
    chk("ill_mem", mem_o, 0);
    chk("ill_wb", wb_o, 0);
    drive(32'h0000_007F, 0, 0, 0);
    cyc();
    chk("ill_end", ill_o, 0);
    cyc();
    chk("ill_inv", ill_o, 0);

    // randomized traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 0 || $urandom_range(0, 1) != 0) inst = rnd_inst();
      vld   = ($urandom_range(0, 99) < 85);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 12);
      if (n == 1500) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
